// File: rtl/link_pkg.sv
// link_pkg: shared link-layer widths and default sizing
package link_pkg;
    localparam int LINK_DATA_W  = 64;
    localparam int LINK_DEPTH   = 4;
    localparam int LINK_CREDITS = 8;
endpackage

// File: rtl/link_fifo.sv
// link_fifo: DEPTH x 64 first-word-fall-through FIFO with occupancy count
module link_fifo
    import link_pkg::*;
#(
    parameter int DEPTH = LINK_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [LINK_DATA_W-1:0]     din,
    output logic [LINK_DATA_W-1:0]     dout,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [LINK_DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]          wr_ptr;
    logic [AW-1:0]          rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    assign dout = mem[rd_ptr];
endmodule

// File: rtl/link_tx_credit_buffer.sv
// link_tx_credit_buffer: credit-gated transmit FIFO with toggle-token credit return
module link_tx_credit_buffer
    import link_pkg::*;
#(
    parameter int DEPTH   = LINK_DEPTH,
    parameter int CREDITS = LINK_CREDITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         core_valid_in,
    input  logic [LINK_DATA_W-1:0]       core_data_in,
    output logic                         core_ready_out,
    output logic                         ser_valid_out,
    output logic [LINK_DATA_W-1:0]       ser_data_out,
    input  logic                         ser_ready_in,
    input  logic                         io_token_in,
    output logic [$clog2(CREDITS+1)-1:0] credit_count,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         credit_overflow
);
    localparam int FW = $clog2(DEPTH + 1);
    localparam int CW = $clog2(CREDITS + 1);
    localparam logic [FW-1:0] FULL     = FW'(DEPTH);
    localparam logic [CW-1:0] MAX_CRED = CW'(CREDITS);

    logic tok_sync1;
    logic tok_sync2;
    logic tok_hist;
    logic tok_ev;
    logic push;
    logic pop;

    assign core_ready_out = fifo_count < FULL;
    assign ser_valid_out  = (fifo_count != '0) && (credit_count != '0);
    assign push           = core_valid_in && core_ready_out;
    assign pop            = ser_valid_out && ser_ready_in;
    assign tok_ev         = tok_sync2 ^ tok_hist;

    link_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (core_data_in),
        .dout  (ser_data_out),
        .count (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            tok_sync1       <= 1'b0;
            tok_sync2       <= 1'b0;
            tok_hist        <= 1'b0;
            credit_count    <= MAX_CRED;
            credit_overflow <= 1'b0;
        end else begin
            tok_sync1       <= io_token_in;
            tok_sync2       <= tok_sync1;
            tok_hist        <= tok_sync2;
            credit_count    <= (tok_ev && !pop && credit_count != MAX_CRED) ? credit_count + 1'b1 :
                               (pop && !tok_ev) ? credit_count - 1'b1 : credit_count;
            credit_overflow <= credit_overflow || (tok_ev && !pop && credit_count == MAX_CRED);
        end
    end
endmodule

// File: tb/tb_link_tx_credit_buffer.sv
// tb_link_tx_credit_buffer: vector table, directed corner sequences and random traffic vs a queue model
module tb_link_tx_credit_buffer;
    localparam int DEPTH   = 4;
    localparam int CREDITS = 8;

    typedef struct {
        logic        r, cv;
        logic [63:0] cd;
        logic        sr, tg;
        bit          en;
        logic        rdy, vld;
        logic [63:0] dat;
        int          fc, cc;
        logic        ov;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        core_valid_in = 1'b0;
    logic [63:0] core_data_in = '0;
    logic        core_ready_out;
    logic        ser_valid_out;
    logic [63:0] ser_data_out;
    logic        ser_ready_in = 1'b0;
    logic        io_token_in = 1'b0;
    logic [3:0]  credit_count;
    logic [2:0]  fifo_count;
    logic        credit_overflow;

    int n_cmp = 0;
    int n_bad = 0;
    int edge_n = 0;

    logic [63:0] q[$];
    int          pend[$];
    int          cred = CREDITS;
    bit          ovf, acc, live;

    vec_t tbl[12];

    always #5 clk = ~clk;

    link_tx_credit_buffer #(.DEPTH(DEPTH), .CREDITS(CREDITS)) dut (
        .clk             (clk),
        .rst             (rst),
        .core_valid_in   (core_valid_in),
        .core_data_in    (core_data_in),
        .core_ready_out  (core_ready_out),
        .ser_valid_out   (ser_valid_out),
        .ser_data_out    (ser_data_out),
        .ser_ready_in    (ser_ready_in),
        .io_token_in     (io_token_in),
        .credit_count    (credit_count),
        .fifo_count      (fifo_count),
        .credit_overflow (credit_overflow)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic model_chk();
        bit v;
        v = q.size() != 0 && cred != 0;
        chk("m.core_ready", 64'(core_ready_out), 64'(q.size() < DEPTH));
        chk("m.ser_valid", 64'(ser_valid_out), 64'(v));
        chk("m.fifo_count", 64'(fifo_count), 64'(q.size()));
        chk("m.credit_count", 64'(credit_count), 64'(cred));
        chk("m.overflow", 64'(credit_overflow), 64'(ovf));
        if (v)
            chk("m.ser_data", ser_data_out, q[0]);
    endtask

    // Credits come from level changes landing three edges after they happen.
    task automatic model_upd(input logic r, input logic cv, input logic [63:0] cd, input logic sr, input logic tg);
        bit hs, pu, tk;
        if (r) begin
            q.delete();
            pend.delete();
            cred = CREDITS;
            ovf  = 0;
            acc  = 0;
            live = 1;
            if (io_token_in)
                pend.push_back(edge_n + 3);
        end else begin
            hs = q.size() != 0 && cred != 0 && sr;
            pu = cv && q.size() < DEPTH;
            tk = pend.size() != 0 && pend[0] == edge_n;
            if (tk) void'(pend.pop_front());
            if (hs) void'(q.pop_front());
            if (pu) q.push_back(cd);
            if (tk && !hs) begin
                if (cred == CREDITS) ovf = 1;
                else cred++;
            end else if (hs && !tk) cred--;
            if (tg) pend.push_back(edge_n + 2);
            acc = pu;
        end
    endtask

    task automatic step(input logic r, input logic cv, input logic [63:0] cd, input logic sr, input logic tg);
        if (live) model_chk();
        rst           = r;
        core_valid_in = cv;
        core_data_in  = cd;
        ser_ready_in  = sr;
        if (tg) io_token_in = ~io_token_in;
        @(posedge clk);
        edge_n++;
        model_upd(r, cv, cd, sr, tg);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic r, cv, input logic [63:0] cd, input logic sr, tg,
                                input bit en, input logic rdy, vld, input logic [63:0] dat,
                                input int fc, cc, input logic ov);
        vec_t t;
        t = '{r, cv, cd, sr, tg, en, rdy, vld, dat, fc, cc, ov};
        return t;
    endfunction

    initial begin
        int w, cool;
        logic r, tg;
        tbl[0]  = mk(1, 0, 64'h0, 0, 0, 0, 0, 0, 64'h0, 0, 0, 0);
        tbl[1]  = mk(0, 1, 64'h1111_2222_3333_4444, 1, 0, 1, 1, 0, 64'h0, 0, 8, 0);
        tbl[2]  = mk(0, 0, 64'h0, 1, 0, 1, 1, 1, 64'h1111_2222_3333_4444, 1, 8, 0);
        tbl[3]  = mk(0, 0, 64'h0, 1, 1, 1, 1, 0, 64'h0, 0, 7, 0);
        tbl[4]  = mk(0, 0, 64'h0, 1, 0, 1, 1, 0, 64'h0, 0, 7, 0);
        tbl[5]  = mk(0, 0, 64'h0, 1, 0, 1, 1, 0, 64'h0, 0, 7, 0);
        tbl[6]  = mk(0, 0, 64'h0, 1, 1, 1, 1, 0, 64'h0, 0, 8, 0);
        tbl[7]  = mk(0, 0, 64'h0, 1, 0, 1, 1, 0, 64'h0, 0, 8, 0);
        tbl[8]  = mk(0, 0, 64'h0, 1, 0, 1, 1, 0, 64'h0, 0, 8, 0);
        tbl[9]  = mk(0, 0, 64'h0, 1, 0, 1, 1, 0, 64'h0, 0, 8, 1);
        tbl[10] = mk(1, 0, 64'h0, 0, 0, 1, 1, 0, 64'h0, 0, 8, 1);
        tbl[11] = mk(0, 0, 64'h0, 0, 0, 1, 1, 0, 64'h0, 0, 8, 0);

        @(negedge clk);
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].en) begin
                chk($sformatf("vec%0d.ready", i), 64'(core_ready_out), 64'(tbl[i].rdy));
                chk($sformatf("vec%0d.valid", i), 64'(ser_valid_out), 64'(tbl[i].vld));
                chk($sformatf("vec%0d.fifo_count", i), 64'(fifo_count), 64'(tbl[i].fc));
                chk($sformatf("vec%0d.credit_count", i), 64'(credit_count), 64'(tbl[i].cc));
                chk($sformatf("vec%0d.overflow", i), 64'(credit_overflow), 64'(tbl[i].ov));
                if (tbl[i].vld)
                    chk($sformatf("vec%0d.data", i), ser_data_out, tbl[i].dat);
            end
            step(tbl[i].r, tbl[i].cv, tbl[i].cd, tbl[i].sr, tbl[i].tg);
        end

        // Backpressure: fifth word waits until the drain frees a slot.
        step(1, 0, 64'h0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 64'hA000 + 64'(i), 0, 0);
        chk("bp.fifo_count", 64'(fifo_count), 64'd4);
        chk("bp.ready", 64'(core_ready_out), 64'd0);
        w = 4;
        for (int i = 0; i < 8; i++) begin
            step(0, w < 5, 64'hA000 + 64'(w), 1, 0);
            if (acc) w++;
        end
        chk("bp.drained", 64'(fifo_count), 64'd0);

        // Credit exhaustion: ninth word waits for a returned token.
        step(1, 0, 64'h0, 0, 0);
        w = 0;
        for (int i = 0; i < 20 && w < 9; i++) begin
            step(0, 1, 64'hB000 + 64'(w), 1, 0);
            if (acc) w++;
        end
        for (int i = 0; i < 3; i++) step(0, 0, 64'h0, 1, 0);
        chk("cr.credit0", 64'(credit_count), 64'd0);
        chk("cr.valid0", 64'(ser_valid_out), 64'd0);
        chk("cr.fifo1", 64'(fifo_count), 64'd1);
        step(0, 0, 64'h0, 1, 1);
        step(0, 0, 64'h0, 1, 0);
        step(0, 0, 64'h0, 1, 0);
        chk("cr.credit1", 64'(credit_count), 64'd1);
        chk("cr.valid1", 64'(ser_valid_out), 64'd1);
        chk("cr.data9", ser_data_out, 64'hB008);
        step(0, 0, 64'h0, 1, 0);
        chk("cr.sent9", 64'(fifo_count), 64'd0);

        // Token event coinciding with a handshake at three credits.
        step(1, 0, 64'h0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 64'hC000 + 64'(i), 0, 0);
        for (int i = 0; i < 6; i++) begin
            step(0, 1, 64'hC100 + 64'(i), 1, i == 3);
            if (i >= 4) chk($sformatf("co.credit3_%0d", i), 64'(credit_count), 64'd3);
        end

        // Reset with queued words discards them and ignores a same-cycle push.
        step(1, 0, 64'h0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 1, 64'hD000 + 64'(i), 0, 0);
        chk("rs.fifo3", 64'(fifo_count), 64'd3);
        step(1, 1, 64'hDEAD, 0, 0);
        chk("rs.fifo0", 64'(fifo_count), 64'd0);
        chk("rs.credit8", 64'(credit_count), 64'd8);
        chk("rs.ready", 64'(core_ready_out), 64'd1);
        for (int i = 0; i < 4; i++) begin
            step(0, 0, 64'h0, 1, 0);
            chk($sformatf("rs.no_stale%0d", i), 64'(ser_valid_out), 64'd0);
        end

        cool = 0;
        for (int i = 0; i < 3000; i++) begin
            r  = $urandom_range(0, 99) == 0;
            tg = !r && cool == 0 && $urandom_range(0, 99) < 15;
            step(r, $urandom_range(0, 9) < 7, {$urandom, $urandom}, $urandom_range(0, 9) < 6, tg);
            cool = r ? 3 : (cool > 0 ? cool - 1 : 0);
        end
        model_chk();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
